// File: rtl/alu_op_sequencer.sv
// Command FIFO plus IDLE/DRIVE/RESP controller that feeds the combinational add/sub ALU
// one command per two cycles. Define ALU_FLAGS_EN to add the res_carry/res_zero outputs.
module alu_op_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_add_sub,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
`ifdef ALU_FLAGS_EN
  ,
  output logic              res_carry,
  output logic              res_zero
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntW = 2 * DATA_W + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e          state_q;
  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            empty, push, pop;
  logic [EntW-1:0] head;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q != FullCnt);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];
  assign busy      = (state_q != StIdle) || !empty;

  // The FSM decides when the head leaves the FIFO; it is consumed in the same edge it loads.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = !empty;
      StResp:  pop = res_ready && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic [DATA_W:0] sum_ext;
  logic            flag_carry;
  assign sum_ext    = {1'b0, alu_a} + {1'b0, alu_b};
  // For subtract the flag reports a borrow rather than the raw adder carry.
  assign flag_carry = alu_add_sub ? sum_ext[DATA_W] : (alu_a < alu_b);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_add_sub <= 1'b0;
      alu_en      <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
`ifdef ALU_FLAGS_EN
      res_carry   <= 1'b0;
      res_zero    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            {alu_add_sub, alu_a, alu_b} <= head;
            alu_en  <= 1'b1;
            state_q <= StDrive;
          end
        end
        StDrive: begin
          alu_en    <= 1'b0;
          res_data  <= alu_result;
          res_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
          res_carry <= flag_carry;
          res_zero  <= (alu_result == '0);
`endif
          state_q   <= StResp;
        end
        StResp: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              {alu_add_sub, alu_a, alu_b} <= head;
              alu_en  <= 1'b1;
              state_q <= StDrive;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          alu_en  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU; flag checks follow ALU_FLAGS_EN.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_a, alu_b, alu_result, res_data;
  logic       alu_add_sub, alu_en, res_valid, res_ready, busy;
`ifdef ALU_FLAGS_EN
  logic       res_carry, res_zero;
`endif

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_add_sub(alu_add_sub),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
`ifdef ALU_FLAGS_EN
    ,
    .res_carry  (res_carry),
    .res_zero   (res_zero)
`endif
  );

  // Combinational add/sub ALU model.
  assign alu_result = alu_add_sub ? (alu_a + alu_b) : (alu_a - alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] res;
    logic       carry;
    logic       zero;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic op);
    logic acc;
    int   n;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      acc = cmd_ready;
      tick();
      n++;
    end
    check("push_accept", acc, 1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] bp_a[6], bp_b[6], bp_exp[5];
    logic       bp_op[6];
    logic       stale;
    int         k, n;

    vecs[0] = '{8'h25, 8'h13, 1'b1, 8'h38, 1'b0, 1'b0};
    vecs[1] = '{8'h05, 8'h0A, 1'b0, 8'hFB, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hA0, 8'h70, 1'b1, 8'h10, 1'b1, 1'b0};
    vecs[5] = '{8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0};

    bp_a = '{8'h01, 8'h10, 8'hF0, 8'h00, 8'h7F, 8'h55};
    bp_b = '{8'h02, 8'h05, 8'h20, 8'h01, 8'h7F, 8'h55};
    bp_op = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bp_exp = '{8'h03, 8'h0B, 8'h10, 8'hFF, 8'hFE};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = 1'b0;
    res_ready = 1'b0;

    // Reset then idle.
    @(posedge clk);
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_add_sub", alu_add_sub, 0);
    check("rst_alu_en", alu_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
`ifdef ALU_FLAGS_EN
    check("rst_res_carry", res_carry, 0);
    check("rst_res_zero", res_zero, 0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_alu_en", alu_en, 0);
      check("idle_busy", busy, 0);
    end

    // Single commands with res_ready high: timing and arithmetic.
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("vec_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_a = vecs[i].a;
      cmd_b = vecs[i].b;
      cmd_op = vecs[i].op;
      tick();
      cmd_valid = 1'b0;
      check("vec_e0_alu_en", alu_en, 0);
      check("vec_e0_busy", busy, 1);
      tick();
      check("vec_e1_alu_en", alu_en, 1);
      check("vec_e1_alu_a", alu_a, vecs[i].a);
      check("vec_e1_alu_b", alu_b, vecs[i].b);
      check("vec_e1_op", alu_add_sub, vecs[i].op);
      check("vec_e1_res_valid", res_valid, 0);
      tick();
      check("vec_e2_res_valid", res_valid, 1);
      check("vec_e2_res_data", res_data, vecs[i].res);
      check("vec_e2_alu_en", alu_en, 0);
`ifdef ALU_FLAGS_EN
      check("vec_e2_res_carry", res_carry, vecs[i].carry);
      check("vec_e2_res_zero", res_zero, vecs[i].zero);
`endif
      tick();
      check("vec_e3_res_valid", res_valid, 0);
      check("vec_e3_busy", busy, 0);
    end

    // Backpressure: five accepted, sixth refused, results in order after release.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(bp_a[i], bp_b[i], bp_op[i]);
    check("bp_full_ready", cmd_ready, 0);
    check("bp_stall_valid", res_valid, 1);
    cmd_valid = 1'b1;
    cmd_a = bp_a[5];
    cmd_b = bp_b[5];
    cmd_op = bp_op[5];
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_refused", cmd_ready, 0);
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_data", res_data, bp_exp[0]);
      check("bp_hold_alu_en", alu_en, 0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    k = 0;
    n = 0;
    while (k < 5 && n < 50) begin
      if (res_valid) begin
        check("bp_result", res_data, bp_exp[k]);
        k++;
      end
      tick();
      n++;
    end
    check("bp_result_count", k, 5);
    check("bp_done_busy", busy, 0);
    check("bp_done_valid", res_valid, 0);

    // Reset while in RESP with three commands queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(bp_a[i], bp_b[i], bp_op[i]);
    check("mid_pre_valid", res_valid, 1);
    check("mid_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_res_valid", res_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_res_data", res_data, 0);
    res_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      stale = stale | res_valid | alu_en | busy;
    end
    check("mid_no_stale", stale, 0);

    push_cmd(8'h12, 8'h34, 1'b1);
    n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
    end
    check("post_rst_valid", res_valid, 1);
    check("post_rst_data", res_data, 8'h46);
    tick();
    check("post_rst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator/controller for the 8-bit combinational add/sub ALU used in the systolic array processing elements.
- Accepts operation commands through a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU operand, mode and enable lines for exactly one cycle per command, registers the ALU result, and presents it on a valid/ready result port.

Parameters:
- DATA_W, 8, operand and result width; must match the ALU width.
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_a  input  DATA_W  first operand.
- cmd_b  input  DATA_W  second operand.
- cmd_op  input  1  1 = add (a+b), 0 = subtract (a-b).
- alu_a  output  DATA_W  to ALU data_in1.
- alu_b  output  DATA_W  to ALU data_in2.
- alu_add_sub  output  1  to ALU add_sub.
- alu_en  output  1  to ALU EnableALU.
- alu_result  input  DATA_W  from ALU out.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_data  output  DATA_W  registered result.
- busy  output  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset and is sampled only on the rising edge of clk.
- Reset values: cmd_ready=1, alu_a=0, alu_b=0, alu_add_sub=0, alu_en=0, res_valid=0, res_data=0, busy=0. FIFO is flushed and the FSM goes to IDLE.
- Reset mid-operation discards queued commands and any pending result.
- Command push: occurs when cmd_valid && cmd_ready at the clock edge.
  - cmd_ready = !full, from the registered count only. A pop in the same cycle does not raise cmd_ready.
  - When full, commands are refused and cmd_valid is held by the sender.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head, load alu_a/alu_b/alu_add_sub from it, and go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: alu_en=1 for exactly this one cycle. At the end of the cycle, res_data <= alu_result, res_valid <= 1, and the FSM goes to RESP.
  - RESP: res_valid=1 and res_data are held stable until res_ready=1. On handshake:
    - if the FIFO is non-empty, pop the next command and go to DRIVE (res_valid drops for one cycle);
    - otherwise clear res_valid and go to IDLE.
- alu_en is 0 in every state except DRIVE. alu_a/alu_b/alu_add_sub hold the last loaded values outside DRIVE.
- Latency: a command pushed at edge E0 into an empty idle block is popped at E1, and res_valid is high after E2. The pushed-to-result-visible latency is 2 cycles.
- Throughput: one result per 2 cycles with res_ready tied high.
- Arithmetic: wrap-around modulo 2^DATA_W, as produced by the ALU. The sequencer does not modify the result.
- Ordering: results are returned strictly in command order, with no drops or duplicates.
- busy = (state != IDLE) || !empty.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: adds outputs res_carry (1 bit) and res_zero (1 bit).
  - res_carry: carry-out of alu_a+alu_b for add, or borrow (alu_a < alu_b) for subtract.
  - res_zero: set when the captured result equals 0.
  - Both are computed from the operand registers in DRIVE, registered with res_data, held with it in RESP, and reset to 0.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold reset 2 cycles -> all outputs 0 except cmd_ready=1; alu_en never pulses.
- Single add: push a=0x25, b=0x13, op=1 with res_ready=1 -> alu_en high for exactly 1 cycle; res_data=0x38 valid 2 cycles after push.
- Subtract wrap: push a=0x05, b=0x0A, op=0 -> res_data=0xFB; with ALU_FLAGS_EN, res_carry=1 and res_zero=0.
- Overflow/zero: push a=0xFF, b=0x01, op=1 -> res_data=0x00; with ALU_FLAGS_EN, res_carry=1 and res_zero=1.
- Backpressure/full: hold res_ready=0 and push 6 commands -> first 1 popped plus 4 queued are accepted, then cmd_ready=0. Release res_ready -> all 5 results in order, each held stable while stalled.
- Reset mid-operation: assert reset while in RESP with 3 commands queued -> next cycle res_valid=0, busy=0, FIFO empty; no stale results after reset is released.
